mul4_rr_scheduler: RTL

- Shares one 4-operand pipelined multiplier (10-bit a,b,c,d -> 40-bit a*b*c*d, fixed latency MUL_LAT) between N_REQ requesters.
- Round-robin arbitration accepts at most one operand set per cycle and drives registered operands into the multiplier.
- A requester-ID tag pipeline, matched to the multiplier latency, routes each product back with its ID.
- Sits between the image-pipeline parameter stages and the shared multiplier in the parameter datapath.

---
 rtl/mul4_rr_scheduler.sv | 117 +++++++++++
 1 files changed

// File: rtl/mul4_rr_scheduler.sv
// Round-robin front end for one shared 4-operand pipelined multiplier (a*b*c*d, 10b -> 40b).
// Ports: clk/rst_n (sync, active-low); pause; req_valid/req_ready/req_a..d per requester;
//        mul_a..d registered operands out, mul_result in; rsp_valid/rsp_id/rsp_data; busy; issue_cnt/rsp_cnt.
module mul4_rr_scheduler #(
   parameter int N_REQ   = 4,
   parameter int ID_W    = 2,
   parameter int MUL_LAT = 4,
   parameter int CNT_W   = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pause,
   input  logic [N_REQ-1:0]      req_valid,
   output logic [N_REQ-1:0]      req_ready,
   input  logic [N_REQ*10-1:0]   req_a,
   input  logic [N_REQ*10-1:0]   req_b,
   input  logic [N_REQ*10-1:0]   req_c,
   input  logic [N_REQ*10-1:0]   req_d,
   output logic [9:0]            mul_a,
   output logic [9:0]            mul_b,
   output logic [9:0]            mul_c,
   output logic [9:0]            mul_d,
   input  logic [39:0]           mul_result,
   output logic                  rsp_valid,
   output logic [ID_W-1:0]       rsp_id,
   output logic [39:0]           rsp_data,
   output logic                  busy,
   output logic [CNT_W-1:0]      issue_cnt,
   output logic [CNT_W-1:0]      rsp_cnt
);

   // Tag stage 0 travels with the operand register; the multiplier samples the
   // operand register one edge later and presents the product MUL_LAT edges after
   // that, so the tag needs MUL_LAT+1 further stages to line up with mul_result.
   localparam int LAST = MUL_LAT + 1;

   logic [ID_W-1:0] ptr;
   logic [ID_W-1:0] idx;
   logic [ID_W-1:0] grant_id;
   logic            grant_vld;
   logic [LAST:0]   tag_vld;
   logic [ID_W-1:0] tag_id [LAST+1];

   // Search upward from the pointer, wrapping; first valid requester wins.
   always_comb begin
      grant_vld = 1'b0;
      grant_id  = '0;
      idx       = '0;
      req_ready = '0;
      if (rst_n && !pause) begin
         for (int k = 0; k < N_REQ; k++) begin
            idx = ID_W'((32'(ptr) + 32'(k)) % N_REQ);
            if (!grant_vld && req_valid[idx]) begin
               grant_vld = 1'b1;
               grant_id  = idx;
            end
         end
      end
      if (grant_vld) begin
         req_ready[grant_id] = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         ptr       <= '0;
         mul_a     <= '0;
         mul_b     <= '0;
         mul_c     <= '0;
         mul_d     <= '0;
         issue_cnt <= '0;
      end else if (grant_vld) begin
         ptr       <= (grant_id == ID_W'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
         mul_a     <= req_a[grant_id*10 +: 10];
         mul_b     <= req_b[grant_id*10 +: 10];
         mul_c     <= req_c[grant_id*10 +: 10];
         mul_d     <= req_d[grant_id*10 +: 10];
         issue_cnt <= issue_cnt + 1'b1;
      end
   end

   // The multiplier has no enable, so tags shift every cycle unconditionally.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tag_vld <= '0;
      end else begin
         tag_vld <= {tag_vld[LAST-1:0], grant_vld};
      end
   end

   always_ff @(posedge clk) begin
      tag_id[0] <= grant_id;
      for (int s = 1; s <= LAST; s++) begin
         tag_id[s] <= tag_id[s-1];
      end
   end

   // The multiplier output is never reset: the tag valid bit is its only qualifier.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_id    <= '0;
         rsp_data  <= '0;
         rsp_cnt   <= '0;
      end else begin
         rsp_valid <= tag_vld[LAST];
         if (tag_vld[LAST]) begin
            rsp_id   <= tag_id[LAST];
            rsp_data <= mul_result;
            rsp_cnt  <= rsp_cnt + 1'b1;
         end
      end
   end

   assign busy = |tag_vld;

endmodule
